// File: rtl/sha256_engine.sv
// ---------------------------------------------------------------------------
// sha256_engine -- SHA-256 compression engine with start/ready/valid handshake
//
// Compresses one 512-bit block per request, running ROUNDS_PER_CYCLE rounds
// per clock.  An internal chaining register keeps the last digest, so
// multi-block and double-hash flows need no external feedback path.
//
// Parameters
//   ROUNDS_PER_CYCLE  rounds per clock (1, 2, 4 or 8); NCYC = 64 / RPC
//   BYTE_SWAP         1: byte-reverse every 32-bit data word before use
//
// Ports
//   clk    in   1    clock, rising edge
//   rst_n  in   1    asynchronous active-low reset
//   start  in   1    compress one block (taken only while ready=1)
//   abort  in   1    cancel the block in progress (no digest update)
//   chain  in   1    sampled with start: 1 = IV from chaining reg, 0 = V_in
//   data   in   512  message block, data[31:0] = W0 .. data[511:480] = W15
//   V_in   in   256  explicit IV, V_in[31:0] = H0 (a) .. V_in[255:224] = H7
//   ready  out  1    idle, start will be taken
//   busy   out  1    ~ready
//   valid  out  1    one-cycle pulse when hash is updated
//   hash   out  256  digest, hash[255:224] = H0 .. hash[31:0] = H7
// ---------------------------------------------------------------------------

package sha256_pkg;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Standard IV, word j = Hj (index 0 = a).
  localparam logic [7:0][31:0] IV_STD = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// ---------------------------------------------------------------------------
// sha256_round -- one combinational SHA-256 round
//   st_i / st_o  working variables, index 0 = a .. 7 = h
//   k_i, w_i     round constant and schedule word for this round
// ---------------------------------------------------------------------------
module sha256_round
  import sha256_pkg::*;
(
  input  logic [7:0][31:0] st_i,
  input  logic [31:0]      k_i,
  input  logic [31:0]      w_i,
  output logic [7:0][31:0] st_o
);

  logic [31:0] t1, t2;

  always_comb begin
    t1 = st_i[7] + bsig1(st_i[4]) + ((st_i[4] & st_i[5]) ^ (~st_i[4] & st_i[6]))
       + k_i + w_i;
    t2 = bsig0(st_i[0]) + ((st_i[0] & st_i[1]) ^ (st_i[0] & st_i[2]) ^ (st_i[1] & st_i[2]));
    st_o[0] = t1 + t2;
    st_o[1] = st_i[0];
    st_o[2] = st_i[1];
    st_o[3] = st_i[2];
    st_o[4] = st_i[3] + t1;
    st_o[5] = st_i[4];
    st_o[6] = st_i[5];
    st_o[7] = st_i[6];
  end

endmodule

// ---------------------------------------------------------------------------
// sha256_engine -- top
// ---------------------------------------------------------------------------
module sha256_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit BYTE_SWAP        = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         chain,
  input  logic [511:0] data,
  input  logic [255:0] V_in,
  output logic         ready,
  output logic         busy,
  output logic         valid,
  output logic [255:0] hash
);

  localparam int         RPC      = ROUNDS_PER_CYCLE;
  localparam int         NCYC     = 64 / RPC;
  localparam logic [5:0] CNT_LAST = 6'(NCYC - 1);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
    $error("sha256_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [7:0][31:0]   v_q, v_d;       // IV of the block in flight
  logic [7:0][31:0]   wk_q, wk_d;     // working variables a..h
  logic [7:0][31:0]   chn_q, chn_d;   // chaining register (last digest)
  logic [15:0][31:0]  w_q, w_d;       // schedule window, w_q[0] = W[cnt*RPC]
  logic [255:0]       hash_q, hash_d;
  logic               valid_q, valid_d;

  logic [7:0][31:0]   iv, dig, rnd_out;
  logic [15:0][31:0]  din, w_nxt;
  logic [31:0]        ext [16+RPC];

  // Schedule: extend the 16-word window by RPC words, then slide by RPC.
  // Words produced this cycle may feed later words of the same cycle
  // (W[t-2] dependency once RPC > 2), so the extension is built in order.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int j = 0; j < RPC; j++)
      ext[16+j] = ext[j] + ssig0(ext[j+1]) + ext[j+9] + ssig1(ext[j+14]);
    for (int k = 0; k < 16; k++) w_nxt[k] = ext[k+RPC];
  end

  // RPC rounds chained combinationally; round i uses W[cnt*RPC + i].
  for (genvar i = 0; i < RPC; i++) begin : g_rnd
    logic [7:0][31:0] st_i, st_o;
    logic [5:0]       k_idx;

    if (i == 0) begin : g_first
      assign st_i = wk_q;
    end else begin : g_chain
      assign st_i = g_rnd[i-1].st_o;
    end

    assign k_idx = 6'(32'(cnt_q) * RPC + i);

    sha256_round u_rnd (
      .st_i (st_i),
      .k_i  (K[k_idx]),
      .w_i  (w_q[i]),
      .st_o (st_o)
    );
  end

  assign rnd_out = g_rnd[RPC-1].st_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    wk_d    = wk_q;
    w_d     = w_q;
    chn_d   = chn_q;
    hash_d  = hash_q;
    valid_d = 1'b0;

    iv = chain ? chn_q : V_in;
    for (int j = 0; j < 8; j++) dig[j] = v_q[j] + wk_q[j];
    for (int i = 0; i < 16; i++)
      din[i] = BYTE_SWAP ? bswap(data[32*i +: 32]) : data[32*i +: 32];

    unique case (state_q)
      S_IDLE: begin
        // abort wins over a simultaneous start: the request is dropped
        if (start && !abort) begin
          v_d     = iv;
          wk_d    = iv;
          w_d     = din;
          cnt_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          wk_d  = rnd_out;
          w_d   = w_nxt;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_FINAL;
          end
        end
      end
      S_FINAL: begin
        state_d = S_IDLE;
        if (!abort) begin
          // hash is presented H0-first in the MSBs, the reverse of V_in
          for (int j = 0; j < 8; j++) hash_d[32*(7-j) +: 32] = dig[j];
          chn_d   = dig;
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      v_q     <= '0;
      wk_q    <= '0;
      w_q     <= '0;
      chn_q   <= IV_STD;
      hash_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      wk_q    <= wk_d;
      w_q     <= w_d;
      chn_q   <= chn_d;
      hash_q  <= hash_d;
      valid_q <= valid_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = ~ready;
  assign valid = valid_q;
  assign hash  = hash_q;

endmodule

// File: tb/tb_sha256_engine.sv
// ---------------------------------------------------------------------------
// tb_sha256_engine -- self-checking bench for sha256_engine.
// Four engines (RPC = 1, 2, 4, 8, all BYTE_SWAP=1) share the inputs; the
// RPC=1 instance (index 0) carries the sequence tests, all four are checked
// in the round-rate sweeps. Expected digests come from published vectors or
// from a straight FIPS-style compression model below.
// ---------------------------------------------------------------------------
module tb_sha256_engine;

  logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, chain = 1'b0;
  logic [511:0] data = '0;
  logic [255:0] v_in = '0;
  logic [3:0]   rdy_a, bsy_a, vld_a;
  logic [255:0] hash_a [4];
  int           n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_engine #(.ROUNDS_PER_CYCLE(1 << g), .BYTE_SWAP(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .chain(chain),
      .data(data), .V_in(v_in), .ready(rdy_a[g]), .busy(bsy_a[g]),
      .valid(vld_a[g]), .hash(hash_a[g])
    );
  end

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV_V  = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [511:0] ABC_D = {32'h18000000, 448'd0, 32'h80636261};
  localparam logic [255:0] ABC_H = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_H = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef struct {
    logic [511:0] data;
    logic [255:0] vin;
    logic         chain;
    logic [255:0] exp;
  } vec_t;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Compression model: iv and result in V_in layout (word j = Hj),
  // message words taken from data and byte-reversed.
  function automatic logic [255:0] model(input logic [255:0] iv, input logic [511:0] d);
    logic [31:0]  w [64];
    logic [31:0]  r [8];
    logic [31:0]  t1, t2, s0, s1;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = bsw(d[32*i +: 32]);
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int j = 0; j < 8; j++) r[j] = iv[32*j +: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = r[7] + (rr(r[4], 6) ^ rr(r[4], 11) ^ rr(r[4], 25))
         + ((r[4] & r[5]) ^ (~r[4] & r[6])) + KT[i] + w[i];
      t2 = (rr(r[0], 2) ^ rr(r[0], 13) ^ rr(r[0], 22))
         + ((r[0] & r[1]) ^ (r[0] & r[2]) ^ (r[1] & r[2]));
      for (int j = 7; j > 0; j--) r[j] = r[j-1];
      r[4] = r[4] + t1;
      r[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) res[32*j +: 32] = iv[32*j +: 32] + r[j];
    return res;
  endfunction

  function automatic logic [255:0] to_hash(input logic [255:0] v);
    logic [255:0] h;
    for (int j = 0; j < 8; j++) h[32*(7-j) +: 32] = v[32*j +: 32];
    return h;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  // Wait (bounded) for valid on the RPC=1 engine; lat counts edges after accept.
  task automatic wait_valid(output logic [255:0] h, output int lat);
    lat = 0;
    h   = '0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (vld_a[0]) begin
        lat = i;
        h   = hash_a[0];
        break;
      end
    end
  endtask

  task automatic accept(input logic [511:0] d, input logic [255:0] v, input logic c);
    @(negedge clk);
    data = d; v_in = v; chain = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_block(input logic [511:0] d, input logic [255:0] v, input logic c,
                           output logic [255:0] h, output int lat);
    accept(d, v, c);
    wait_valid(h, lat);
  endtask

  // "abc" on all four engines at once; inputs are scrambled after accept.
  task automatic sweep(input logic [255:0] v, input logic c, input string tag);
    int           lt [4];
    logic [255:0] hv [4];
    for (int g = 0; g < 4; g++) begin lt[g] = 0; hv[g] = '0; end
    accept(ABC_D, v, c);
    data = rnd512(); v_in = rnd256(); chain = ~c;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++)
        if (vld_a[g] && lt[g] == 0) begin lt[g] = i; hv[g] = hash_a[g]; end
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("%s_rpc%0d_hash", tag, 1 << g), hv[g], ABC_H);
      chk_i($sformatf("%s_rpc%0d_lat", tag, 1 << g), lt[g], (64 >> g) + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tab [8];
    logic [255:0] mch, h, e, rv, cur_v;
    logic [511:0] rd, b1, b2;
    logic [31:0]  msg [14];
    int           lat, nv;

    // ---- reset state ----
    #2 rst_n = 1'b0;
    #20;
    for (int g = 0; g < 4; g++) begin
      chk_i($sformatf("rst_ready%0d", g), int'(rdy_a[g]), 1);
      chk_i($sformatf("rst_busy%0d", g), int'(bsy_a[g]), 0);
      chk_i($sformatf("rst_valid%0d", g), int'(vld_a[g]), 0);
      chk($sformatf("rst_hash%0d", g), hash_a[g], '0);
    end
    @(negedge clk) rst_n = 1'b1;

    // ---- chain=1 straight after reset (reset IV), then chain=0 with IV ----
    sweep(rnd256(), 1'b1, "rstiv");
    sweep(IV_V, 1'b0, "abc");

    // ---- vector table: random blocks, some chained, one all-ones ----
    tab[0] = '{ABC_D, IV_V, 1'b0, ABC_H};
    mch = model(IV_V, ABC_D);
    for (int t = 1; t < 8; t++) begin
      logic c;
      rd = rnd512();
      rv = rnd256();
      c  = (t % 3 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (t == 2) begin rd = '1; rv = '1; c = 1'b0; end
      e = model(c ? mch : rv, rd);
      tab[t] = '{rd, rv, c, to_hash(e)};
      mch = e;
    end
    for (int t = 0; t < 8; t++) begin
      run_block(tab[t].data, tab[t].vin, tab[t].chain, h, lat);
      chk($sformatf("vec%0d_hash", t), h, tab[t].exp);
      chk_i($sformatf("vec%0d_lat", t), lat, 65);
    end

    // ---- two-block message, block 2 issued in the valid cycle ----
    msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
            32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
            32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
    b1 = '0;
    for (int i = 0; i < 14; i++) b1[32*i +: 32] = bsw(msg[i]);
    b1[32*14 +: 32] = bsw(32'h80000000);
    b2 = '0;
    b2[32*15 +: 32] = bsw(32'h000001c0);
    run_block(b1, IV_V, 1'b0, h, lat);
    chk("two_blk1_hash", h, to_hash(model(IV_V, b1)));
    data = b2; v_in = rnd256(); chain = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_i("two_b2b_accept", int'(rdy_a[0]), 0);
    wait_valid(h, lat);
    chk("two_blk2_hash", h, TWO_H);
    chk_i("two_blk2_lat", lat, 65);

    // ---- abort at cnt=30, then restart ----
    accept(ABC_D, IV_V, 1'b0);
    repeat (30) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk_i("abort30_ready", int'(rdy_a[0]), 1);
    nv = 0;
    for (int i = 0; i < 80; i++) begin @(posedge clk); #1; nv += int'(vld_a[0]); end
    chk_i("abort30_no_valid", nv, 0);
    chk("abort30_hash_hold", hash_a[0], TWO_H);
    run_block(ABC_D, IV_V, 1'b0, h, lat);
    chk("restart_hash", h, ABC_H);
    chk_i("restart_lat", lat, 65);
    cur_v = model(IV_V, ABC_D);

    // ---- abort in FINAL: no digest, chain register untouched ----
    accept(rnd512(), rnd256(), 1'b0);
    repeat (64) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    nv = int'(vld_a[0]);
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; nv += int'(vld_a[0]); end
    chk_i("abortfin_no_valid", nv, 0);
    chk("abortfin_hash_hold", hash_a[0], ABC_H);
    rd = rnd512();
    run_block(rd, rnd256(), 1'b1, h, lat);
    chk("abortfin_chain_hash", h, to_hash(model(cur_v, rd)));

    // ---- start pulses while busy are ignored, inputs change mid-block ----
    rd = rnd512();
    rv = rnd256();
    accept(rd, rv, 1'b0);
    lat = 0;
    h   = '0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      start = (i == 5 || i == 20);
      if (start) begin data = rnd512(); v_in = rnd256(); chain = 1'b1; end
      if (vld_a[0]) begin lat = i; h = hash_a[0]; break; end
    end
    start = 1'b0;
    chk("busy_start_hash", h, to_hash(model(rv, rd)));
    chk_i("busy_start_lat", lat, 65);
    @(posedge clk); #1;
    chk_i("busy_start_noqueue", int'(rdy_a[0]), 1);

    // ---- asynchronous reset at cnt=40 ----
    accept(ABC_D, IV_V, 1'b0);
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_i("arst_ready", int'(rdy_a[0]), 1);
    chk_i("arst_busy", int'(bsy_a[0]), 0);
    chk_i("arst_valid", int'(vld_a[0]), 0);
    chk("arst_hash", hash_a[0], '0);
    @(negedge clk) rst_n = 1'b1;
    run_block(ABC_D, rnd256(), 1'b1, h, lat);
    chk("arst_chain_iv_hash", h, ABC_H);
    chk_i("arst_chain_iv_lat", lat, 65);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
